// File: rtl/debouncer.sv
// debouncer: accepts a 4-bit keypad code only after the raw key-down strobe
// has stayed high, with an unchanged code, long enough to ride out contact
// bounce. A release is debounced the same way before a new press is armed.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   sig_in       raw key code from the scanner
//   key_pressed  raw (bouncy) key-down indication
//   sig_out      debounced key code, registered
module debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 960000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sig_in,
    input  logic       key_pressed,
    output logic [3:0] sig_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    state_t           state, state_d;
    logic [CNT_W-1:0] counter, counter_d;
    logic [CNT_W-1:0] counter_inc;
    logic [3:0]       candidate, candidate_d;
    logic [3:0]       sig_out_q, sig_out_d;
    logic             counter_done;

    assign counter_done = (counter == CNT_MAX);

    // Saturating increment: the counter never runs past the terminal count.
    assign counter_inc = counter_done ? counter : counter + CNT_W'(1);

    assign sig_out = sig_out_q;

    always_comb begin
        state_d     = state;
        counter_d   = counter;
        candidate_d = candidate;
        sig_out_d   = sig_out_q;

        case (state)
            IDLE: begin
                if (key_pressed) begin
                    // A new press always clears the previously accepted code.
                    state_d     = DEBOUNCE;
                    counter_d   = CNT_W'(1);
                    candidate_d = sig_in;
                    sig_out_d   = '0;
                end
            end

            DEBOUNCE: begin
                if (!key_pressed) begin
                    state_d   = IDLE;
                    counter_d = '0;
                end else if (sig_in != candidate) begin
                    // Code changed mid-press: restart the qualification window.
                    candidate_d = sig_in;
                    counter_d   = CNT_W'(1);
                end else if (counter_done) begin
                    state_d   = PRESSED;
                    sig_out_d = candidate;
                    counter_d = '0;
                end else begin
                    counter_d = counter_inc;
                end
            end

            PRESSED: begin
                if (!key_pressed) begin
                    state_d   = RELEASE;
                    counter_d = CNT_W'(1);
                end
            end

            RELEASE: begin
                if (key_pressed) begin
                    // Bounce during release: start the release window over.
                    counter_d = '0;
                end else if (counter_done) begin
                    state_d   = IDLE;
                    counter_d = '0;
                end else begin
                    counter_d = counter_inc;
                end
            end

            default: begin
                state_d     = IDLE;
                counter_d   = '0;
                candidate_d = '0;
                sig_out_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            counter   <= '0;
            candidate <= '0;
            sig_out_q <= '0;
        end else begin
            state     <= state_d;
            counter   <= counter_d;
            candidate <= candidate_d;
            sig_out_q <= sig_out_d;
        end
    end

endmodule

// File: tb/tb_debouncer.sv
`timescale 1ns/1ps
module tb_debouncer;

    localparam int unsigned N = 20;

    logic       clk;
    logic       reset;
    logic [3:0] sig_in;
    logic       key_pressed;
    logic [3:0] sig_out;

    typedef struct {
        string      tag;
        logic [3:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp;
    int   n_err;

    debouncer #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sig_in      (sig_in),
        .key_pressed (key_pressed),
        .sig_out     (sig_out)
    );

    // 1 MHz clock
    initial clk = 1'b0;
    always #500 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        reset       = 1'b0;
        sig_in      = 4'b0000;
        key_pressed = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back('{tag:"reset_held", val:4'b0000});
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back('{tag:"reset_idle", val:4'b0000});
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        n_cmp++;
        if (dut.state !== 2'd0) begin n_err++; $display("FAIL reset_state: state=%0d expected 0", dut.state); end
        n_cmp++;
        if (dut.counter !== 5'd0) begin n_err++; $display("FAIL reset_counter: counter=%0d expected 0", dut.counter); end
    endtask

    task automatic test_glitch();
        sig_in = 4'b0001; key_pressed = 1'b1;
        exp_q.push_back('{tag:"glitch", val:4'b0000});
        repeat (5) @(negedge clk);
        key_pressed = 1'b0;
        repeat (10) @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        n_cmp++;
        if (dut.state !== 2'd0) begin n_err++; $display("FAIL glitch_state: state=%0d expected 0", dut.state); end
    endtask

    task automatic test_accept();
        sig_in = 4'b0010; key_pressed = 1'b1;
        exp_q.push_back('{tag:"accept_20_high", val:4'b0000});
        repeat (20) @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        n_cmp++;
        if (dut.counter !== 5'd20) begin n_err++; $display("FAIL accept_counter: counter=%0d expected 20", dut.counter); end
        exp_q.push_back('{tag:"accept_30_high", val:4'b0010});
        repeat (10) @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        n_cmp++;
        if (dut.state !== 2'd2) begin n_err++; $display("FAIL accept_state: state=%0d expected 2", dut.state); end
        // release with one bounce part way through
        key_pressed = 1'b0;
        repeat (10) @(negedge clk);
        key_pressed = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dut.counter !== 5'd0 || dut.state !== 2'd3)
            begin n_err++; $display("FAIL release_bounce: state=%0d counter=%0d expected 3/0", dut.state, dut.counter); end
        key_pressed = 1'b0;
        exp_q.push_back('{tag:"accept_released", val:4'b0010});
        repeat (35) @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        n_cmp++;
        if (dut.state !== 2'd0) begin n_err++; $display("FAIL release_state: state=%0d expected 0", dut.state); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] codes [3];
        codes[0] = 4'b0100; codes[1] = 4'b0101; codes[2] = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            sig_in = codes[i]; key_pressed = 1'b1;
            exp_q.push_back('{tag:"quick_high", val:4'b0000});
            exp_q.push_back('{tag:"quick_low", val:4'b0000});
            repeat (5) @(negedge clk);
            e = exp_q.pop_front(); n_cmp++;
            if (sig_out !== e.val) begin n_err++; $display("FAIL %s[%0d]: sig_out=%b expected %b", e.tag, i, sig_out, e.val); end
            key_pressed = 1'b0;
            repeat (5) @(negedge clk);
            e = exp_q.pop_front(); n_cmp++;
            if (sig_out !== e.val) begin n_err++; $display("FAIL %s[%0d]: sig_out=%b expected %b", e.tag, i, sig_out, e.val); end
        end
    endtask

    task automatic test_boundary();
        sig_in = 4'b1000; key_pressed = 1'b1;
        exp_q.push_back('{tag:"short_19", val:4'b0000});
        repeat (19) @(negedge clk);
        key_pressed = 1'b0;
        repeat (5) @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        sig_in = 4'b1001; key_pressed = 1'b1;
        exp_q.push_back('{tag:"hold_20", val:4'b0000});
        exp_q.push_back('{tag:"hold_21", val:4'b1001});
        exp_q.push_back('{tag:"hold_released", val:4'b1001});
        repeat (20) @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        key_pressed = 1'b0;
        repeat (25) @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        n_cmp++;
        if (dut.state !== 2'd0) begin n_err++; $display("FAIL boundary_state: state=%0d expected 0", dut.state); end
    endtask

    task automatic test_restart();
        key_pressed = 1'b1;
        exp_q.push_back('{tag:"toggle", val:4'b0000});
        for (int s = 0; s < 4; s++) begin
            sig_in = (s % 2 == 0) ? 4'b0011 : 4'b0111;
            repeat (10) @(negedge clk);
        end
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        n_cmp++;
        if (dut.counter !== 5'd10 || dut.state !== 2'd1)
            begin n_err++; $display("FAIL toggle_counter: state=%0d counter=%0d expected 1/10", dut.state, dut.counter); end
        // asynchronous reset between clock edges, mid-debounce
        #100;
        reset = 1'b0;
        exp_q.push_back('{tag:"reset_mid_debounce", val:4'b0000});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        n_cmp++;
        if (dut.state !== 2'd0 || dut.counter !== 5'd0)
            begin n_err++; $display("FAIL reset_mid_state: state=%0d counter=%0d expected 0/0", dut.state, dut.counter); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_pressed();
        sig_in = 4'b0011; key_pressed = 1'b1;
        exp_q.push_back('{tag:"pressed_before_reset", val:4'b0011});
        repeat (25) @(negedge clk);
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        #100;
        reset = 1'b0;
        exp_q.push_back('{tag:"reset_in_pressed", val:4'b0000});
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (sig_out !== e.val) begin n_err++; $display("FAIL %s: sig_out=%b expected %b", e.tag, sig_out, e.val); end
        n_cmp++;
        if (dut.state !== 2'd0) begin n_err++; $display("FAIL reset_pressed_state: state=%0d expected 0", dut.state); end
        @(negedge clk);
        key_pressed = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_glitch();
        test_accept();
        test_back_to_back();
        test_boundary();
        test_restart();
        test_reset_pressed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
